// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V pipeline types, load funct3 encodings and default widths
package riscv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// load_extend: picks the addressed byte/half of an aligned memory word and sign/zero extends it
module load_extend
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] word_i,
    input  logic [1:0]      offset_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] value_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // halfword loads use only offset bit 1; bit 0 is ignored
    assign byte_sel = word_i[{offset_i, 3'b000} +: 8];
    assign half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        value_o = funct3_i == F3_LB  ? {{(XLEN-8){byte_sel[7]}}, byte_sel} :
                  funct3_i == F3_LH  ? {{(XLEN-16){half_sel[15]}}, half_sel} :
                  funct3_i == F3_LBU ? {{(XLEN-8){1'b0}}, byte_sel} :
                  funct3_i == F3_LHU ? {{(XLEN-16){1'b0}}, half_sel} :
                                       word_i;
    end

endmodule

// File: rtl/writeback_regfile.sv
// writeback_regfile: writeback result select feeding a write-first bypassing register file
module writeback_regfile
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteW,
    input  logic [1:0]      ResultSrcW,
    input  logic [2:0]      Funct3W,
    input  logic [XLEN-1:0] ALUResultW,
    input  logic [XLEN-1:0] ReadDataW,
    input  logic [XLEN-1:0] PCPlus4W,
    input  logic [4:0]      RdW,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    output logic [XLEN-1:0] RD1D,
    output logic [XLEN-1:0] RD2D,
    output logic [XLEN-1:0] ResultW
);

    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [XLEN-1:0] regs_d [1:NREG-1];
    logic [XLEN-1:0] load_val;
    logic            wr_en;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .word_i   (ReadDataW),
        .offset_i (ALUResultW[1:0]),
        .funct3_i (Funct3W),
        .value_o  (load_val)
    );

    assign ResultW = result_src_e'(ResultSrcW) == RES_MEM ? load_val :
                     result_src_e'(ResultSrcW) == RES_PC4 ? PCPlus4W : ALUResultW;

    // x0 and indices beyond the register count are never written
    assign wr_en = RegWriteW && RdW != 5'd0 && int'(RdW) < NREG && !reset;

    function automatic logic [XLEN-1:0] read_port(input logic [4:0] rs);
        return (rs == 5'd0 || int'(rs) >= NREG) ? '0 :
               (wr_en && rs == RdW)             ? ResultW : regs_q[rs];
    endfunction

    assign RD1D = read_port(Rs1D);
    assign RD2D = read_port(Rs2D);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[RdW] = ResultW;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width of result path and registers.
REQ-002 SHALL have parameter NREG, default 32: architectural register count; x0 included.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on posedge.
REQ-004 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-005 SHALL have port RegWriteW  in  1: writeback enable from the MEM/WB register.
REQ-006 SHALL have port ResultSrcW  in  2: result select (00 ALU, 01 load, 10 PC+4, 11 reserved).
REQ-007 SHALL have port Funct3W  in  3: load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
REQ-008 SHALL have ports ALUResultW, ReadDataW, PCPlus4W  in  XLEN each: MEM/WB payload; ReadDataW is the raw aligned memory word.
REQ-009 SHALL have port RdW  in  5: destination register index.
REQ-010 SHALL have ports Rs1D, Rs2D  in  5 each: decode-stage source indices.
REQ-011 SHALL have ports RD1D, RD2D  out  XLEN each: source operand values to decode.
REQ-012 SHALL have port ResultW  out  XLEN: selected writeback value, also exported for hazard forwarding.

Function
REQ-013 SHALL drive ResultW combinationally: 00 -> ALUResultW; 01 -> extended load data; 10 -> PCPlus4W; 11 -> ALUResultW.
REQ-014 SHALL extract load data by byte offset ALUResultW[1:0]: LB/LBU select byte lane [8*off+7:8*off]; LH/LHU select half ALUResultW[1] (bit 0 ignored); LW passes the full word.
REQ-015 SHALL sign-extend for LB/LH, zero-extend for LBU/LHU; unlisted Funct3W values SHALL behave as LW.
REQ-016 SHALL hold NREG-1 XLEN-bit registers for x1..x31; x0 SHALL always read 0 and ignore writes.
REQ-017 SHALL write ResultW into register RdW at posedge clk when RegWriteW=1, RdW!=0, reset=0; no other write path exists.
REQ-018 SHALL read RD1D/RD2D combinationally, 0-cycle latency from Rs1D/Rs2D.
REQ-019 SHALL bypass (write-first): when RegWriteW=1, RdW!=0, reset=0 and RsXD==RdW, RDXD SHALL equal this cycle's ResultW.
REQ-020 SHALL apply bypass independently to both ports; Rs1D==Rs2D==RdW SHALL bypass both.
REQ-021 SHALL return 0 on RDXD for RsXD=0 regardless of bypass conditions.
REQ-022 SHALL need no handshake: every cycle with RegWriteW=1 commits exactly one write; no stall input exists.

Reset
REQ-023 SHALL clear x1..x31 to 0 at posedge clk while reset=1.
REQ-024 SHALL drop any write presented in a reset cycle; reset takes priority over RegWriteW.
REQ-025 SHALL disable bypass while reset=1; RD1D/RD2D then show stored (post-reset 0) values.
REQ-026 SHALL leave ResultW purely combinational, unaffected by reset.

Structure
REQ-027 SHALL import from shared package riscv_pkg: result_src_e enum (RES_ALU, RES_MEM, RES_PC4), load funct3 constants, XLEN/NREG defaults.
REQ-028 SHALL place load extraction/extension in one sub-module load_extend (inputs word, offset, funct3; output XLEN value).
REQ-029 SHALL keep register storage, write logic and bypass in the top module.

Verification
REQ-030 SHALL test: write x5=0xDEADBEEF (ResultSrcW=00), next cycle Rs1D=5 -> RD1D=0xDEADBEEF.
REQ-031 SHALL test: RegWriteW=1, RdW=0, ALUResultW=0x1234; Rs1D=0 -> RD1D=0 same and next cycle.
REQ-032 SHALL test: ReadDataW=0x80FF7F01, ResultSrcW=01, offset 1 -> LB=0x0000007F, offset 2 -> LB=0xFFFFFFFF, LBU=0x000000FF; offset 2 LH=0xFFFF80FF, LHU=0x000080FF.
REQ-033 SHALL test: RegWriteW=1, RdW=7, ResultSrcW=10, PCPlus4W=0x104, Rs1D=Rs2D=7 same cycle -> RD1D=RD2D=0x104 (bypass).
REQ-034 SHALL test: x9=0x55 written, then reset=1 with RegWriteW=1, RdW=9, ALUResultW=0xAA -> after reset RD of x9=0; bypass absent during reset.
REQ-035 SHALL test: Funct3W=011, ResultSrcW=01, ReadDataW=0xCAFEF00D -> ResultW=0xCAFEF00D.
